memory_stage: RTL
=================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter WORD, default 64: data/address width in bits; SHALL be 32 or 64.
REQ-002 Parameter DEPTH, default 128: data memory size in WORD-wide entries; SHALL be a power of two.
REQ-003 Parameter MEM_LAT, default 2: read latency in cycles; SHALL be 1..4.
REQ-004 Ports SHALL be:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  upstream instruction present.
- stall_out  out  1  stage busy; upstream holds.
- uncondbranch  in  1  B/BL.
- branch  in  1  conditional branch.
- branch_nz  in  1  CBNZ sense (0 = CBZ).
- zero  in  1  ALU zero flag.
- MemRead  in  1  load.
- MemWrite  in  1  store.
- size  in  2  access size: 0 = byte, 1 = half, 2 = word32, 3 = dword (3 legal only when WORD = 64).
- address  in  WORD  byte address.
- write_data  in  WORD  store data, LSB-aligned.
- pc_src  out  1  branch taken.
- read_data  out  WORD  load result.
- valid_out  out  1  one-cycle completion pulse.
- mem_err  out  1  access rejected; qualified by valid_out.

Function
REQ-005 Accept SHALL occur on a rising edge where valid_in=1 and stall_out=0, called edge E0; inputs are sampled only at E0.
REQ-006 pc_src SHALL be registered at E0 as uncondbranch | (branch & (zero ^ branch_nz)), and SHALL be presented only while valid_out=1, 0 otherwise.
REQ-007 Memory SHALL be DEPTH x WORD, byte-addressed.
- Entry index = address bits [log2(DEPTH)+log2(WORD/8)-1 : log2(WORD/8)].
- Higher address bits are ignored, so addresses wrap modulo DEPTH*WORD/8.
REQ-008 Access SHALL be misaligned when address mod (1<<size) != 0, and illegal when size=3 with WORD=32 or when MemRead=MemWrite=1.
REQ-009 A misaligned or illegal access SHALL perform no memory write, SHALL leave read_data unchanged, and SHALL complete as a non-read op with mem_err=1.
REQ-010 A legal store SHALL write only the addressed byte lanes (low bytes of write_data) at E0, leave the other lanes unchanged, and complete as a non-read op.
REQ-011 Non-read op (store, branch, NOP, error): valid_out=1 for the single cycle between E0 and E1; stall_out stays 0.
REQ-012 Legal load FSM SHALL have states IDLE -> RD_WAIT -> IDLE.
- Counter is loaded with MEM_LAT-1 at E0.
- stall_out=1 while in RD_WAIT.
- Counter decrements each edge.
- At count 0 the FSM returns to IDLE.
- valid_out=1 for the cycle between E(MEM_LAT-1) and E(MEM_LAT).
REQ-013 With MEM_LAT=1 a load SHALL behave like REQ-011: no stall, data valid in the cycle after E0.
REQ-014 Load data SHALL be the addressed bytes zero-extended to WORD; read_data SHALL update only on load completion and hold until the next load completes.
REQ-015 A store to the address of an in-flight load cannot occur, because stall_out blocks acceptance; back-to-back loads SHALL sustain one load per MEM_LAT cycles.
REQ-016 mem_err SHALL be 0 whenever valid_out=0.
REQ-017 valid_in asserted while stall_out=1 SHALL be ignored with no side effects.

Reset
REQ-018 rst_n=0 SHALL immediately force FSM=IDLE, counter=0, stall_out=0, valid_out=0, pc_src=0, mem_err=0, read_data=0.
REQ-019 Memory contents SHALL NOT be reset.
REQ-020 Reset asserted during RD_WAIT SHALL abort the load with no valid_out pulse; the first accept after release starts from IDLE.

Verification
REQ-021 The bench SHALL cover:
- WORD=64, MEM_LAT=2: store dword 0x1122334455667788 at 0x10, then load dword 0x10 -> stall_out=1 for 1 cycle, valid_out after 2 cycles, read_data=0x1122334455667788, mem_err=0.
- Store byte 0xAA at 0x13 over the prior value, then load dword 0x10 -> 0x11223344AA667788; load byte 0x13 -> 0x00000000000000AA.
- Load half at 0x11 -> valid_out after 1 cycle, mem_err=1, memory and read_data unchanged; MemRead=MemWrite=1 -> mem_err=1.
- Branches: branch=1, zero=1, branch_nz=0 -> pc_src=1; branch_nz=1, zero=1 -> pc_src=0; uncondbranch=1 -> pc_src=1; each with a 1-cycle valid_out.
- DEPTH=128: store at 0x400 then load at 0x000 -> same data (wrap).
- MEM_LAT=4: rst_n pulsed low during RD_WAIT -> no valid_out, all outputs 0; MEM_LAT=1 back-to-back loads -> one valid_out per cycle, stall_out never 1.

Source files
------------

// File: rtl/memory_stage.sv
// Memory pipeline stage: branch resolution plus a byte-addressed data memory
// with sized, zero-extending loads and byte-lane stores; loads take MEM_LAT cycles.
module memory_stage #(
    parameter int WORD    = 64,
    parameter int DEPTH   = 128,
    parameter int MEM_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    output logic            stall_out,
    input  logic            uncondbranch,
    input  logic            branch,
    input  logic            branch_nz,
    input  logic            zero,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [1:0]      size,
    input  logic [WORD-1:0] address,
    input  logic [WORD-1:0] write_data,
    output logic            pc_src,
    output logic [WORD-1:0] read_data,
    output logic            valid_out,
    output logic            mem_err
);
    localparam int NB = WORD / 8;
    localparam int BW = $clog2(NB);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t          state;
    logic [1:0]      cnt;
    logic [AW-1:0]   idx_q;
    logic [BW-1:0]   off_q;
    logic [1:0]      size_q;
    logic            pc_q;
    logic [WORD-1:0] mem [DEPTH];

    logic            accept, mis, ill, err, is_load, is_store, take;
    logic [AW-1:0]   idx;
    logic [BW-1:0]   off;
    logic [NB-1:0]   be;
    logic [WORD-1:0] wsh;
    logic            unused_addr;

    assign stall_out   = (state == RD_WAIT);
    assign accept      = valid_in & ~stall_out;
    assign idx         = address[AW+BW-1:BW];
    assign off         = address[BW-1:0];
    // Bits above the memory span are dropped so addresses wrap.
    assign unused_addr = ^address[WORD-1:AW+BW];
    assign take        = uncondbranch | (branch & (zero ^ branch_nz));
    assign wsh         = write_data << {off, 3'b000};

    always_comb begin
        mis = 1'b0;
        case (size)
            2'd0: mis = 1'b0;
            2'd1: mis = address[0];
            2'd2: mis = |address[1:0];
            2'd3: mis = |address[2:0];
        endcase
        ill      = ((size == 2'd3) && (WORD == 32)) || (MemRead && MemWrite);
        err      = (MemRead | MemWrite) & (mis | ill);
        is_load  = MemRead & ~MemWrite & ~err;
        is_store = MemWrite & ~MemRead & ~err;
        be       = '0;
        for (int b = 0; b < NB; b++)
            be[b] = (b >= int'(off)) && (b < int'(off) + (1 << size));
    end

    function automatic logic [WORD-1:0] extract(input logic [WORD-1:0] w,
                                                input logic [BW-1:0]   o,
                                                input logic [1:0]      s);
        logic [WORD-1:0] sh, m;
        sh = w >> {o, 3'b000};
        case (s)
            2'd0:    m = WORD'(8'hFF);
            2'd1:    m = WORD'(16'hFFFF);
            2'd2:    m = WORD'(32'hFFFF_FFFF);
            default: m = '1;
        endcase
        return sh & m;
    endfunction

    // Stores land at accept; a pending load cannot be overtaken since stall blocks accept.
    always_ff @(posedge clk) begin
        if (accept && is_store)
            for (int b = 0; b < NB; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx_q     <= '0;
            off_q     <= '0;
            size_q    <= '0;
            pc_q      <= 1'b0;
            valid_out <= 1'b0;
            mem_err   <= 1'b0;
            pc_src    <= 1'b0;
            read_data <= '0;
        end else begin
            valid_out <= 1'b0;
            mem_err   <= 1'b0;
            pc_src    <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (is_load && MEM_LAT > 1) begin
                        state  <= RD_WAIT;
                        cnt    <= 2'(MEM_LAT - 1);
                        idx_q  <= idx;
                        off_q  <= off;
                        size_q <= size;
                        pc_q   <= take;
                    end else begin
                        valid_out <= 1'b1;
                        mem_err   <= err;
                        pc_src    <= take;
                        if (is_load) read_data <= extract(mem[idx], off, size);
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state     <= IDLE;
                        valid_out <= 1'b1;
                        pc_src    <= pc_q;
                        read_data <= extract(mem[idx_q], off_q, size_q);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
